// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - one-command-at-a-time driver for the combinational ALU
// Accepts a command, runs the ALU for one cycle, captures into acc and hands the result off.
module alu_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_acc,
  input  logic             cmd_clr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_err,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t           state;
  logic             op_bad;
  logic [WIDTH-1:0] captured;

  // alu_op is only non-NOP during EXEC, so it doubles as the latched opcode there
  always_comb begin
    op_bad   = (alu_op > 5'h06);
    captured = alu_out;
    if (op_bad || alu_op == 5'h00) captured = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b1;
      res_err   <= 1'b0;
      acc       <= '0;
      op_count  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 5'h00;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_op    <= cmd_op;
            alu_b     <= cmd_b;
            alu_a     <= cmd_acc ? (cmd_clr ? '0 : acc) : cmd_a;
            if (cmd_clr) acc <= '0;
            cmd_ready <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          res_data  <= captured;
          res_err   <= op_bad;
          res_zero  <= (captured == '0);
          acc       <= captured;
          res_valid <= 1'b1;
          alu_op    <= 5'h00;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          alu_op    <= 5'h00;
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed bench for alu_op_sequencer with a behavioural ALU
// Narrow op counter so the wrap-around can be reached quickly.
module tb_alu_op_sequencer;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_acc, cmd_clr;
  logic [4:0]       cmd_op, alu_op;
  logic [WIDTH-1:0] cmd_a, cmd_b, alu_a, alu_b, alu_out;
  logic             res_valid, res_ready, res_zero, res_err;
  logic [WIDTH-1:0] res_data, acc;
  logic [CNT_W-1:0] op_count;
  logic [CNT_W-1:0] exp_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc), .cmd_clr(cmd_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_err(res_err), .acc(acc), .op_count(op_count)
  );

  // Unknown opcodes return junk so a missing force-to-zero shows up
  always_comb begin
    alu_out = 32'hDEADBEEF;
    case (alu_op)
      5'h00: alu_out = '0;
      5'h01: alu_out = alu_a + alu_b;
      5'h02: alu_out = alu_a - alu_b;
      5'h03: alu_out = alu_a & alu_b;
      5'h04: alu_out = alu_a | alu_b;
      5'h05: alu_out = alu_a ^ alu_b;
      5'h06: alu_out = ~(alu_a | alu_b);
      default: alu_out = 32'hDEADBEEF;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one command from IDLE; returns one cycle after capture (in HOLD)
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic accm, input logic clr);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = accm; cmd_clr = clr;
    tick();
    cmd_valid = 1'b0;
    tick();
  endtask

  task automatic take();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, ".res_valid"}, 32'(res_valid), 32'd0);
    check({tag, ".res_data"},  res_data, 32'd0);
    check({tag, ".res_zero"},  32'(res_zero), 32'd1);
    check({tag, ".res_err"},   32'(res_err), 32'd0);
    check({tag, ".acc"},       acc, 32'd0);
    check({tag, ".op_count"},  32'(op_count), 32'd0);
    check({tag, ".alu_a"},     alu_a, 32'd0);
    check({tag, ".alu_b"},     alu_b, 32'd0);
    check({tag, ".alu_op"},    32'(alu_op), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_acc = 1'b0; cmd_clr = 1'b0; res_ready = 1'b0; exp_cnt = '0;
    #1;
    check_reset_values("rst0");
    tick(); tick();
    #3 rst = 1'b0;
    tick();

    // ADD 5+7 with cycle-by-cycle latency and alu_op visibility
    check("t1.idle_op", 32'(alu_op), 32'd0);
    cmd_valid = 1'b1; cmd_op = 5'h01; cmd_a = 32'd5; cmd_b = 32'd7;
    tick();
    cmd_valid = 1'b0;
    check("t1.exec_ready", 32'(cmd_ready), 32'd0);
    check("t1.exec_op", 32'(alu_op), 32'd1);
    check("t1.exec_a", alu_a, 32'd5);
    check("t1.exec_b", alu_b, 32'd7);
    check("t1.exec_valid", 32'(res_valid), 32'd0);
    tick();
    check("t1.valid", 32'(res_valid), 32'd1);
    check("t1.data", res_data, 32'd12);
    check("t1.zero", 32'(res_zero), 32'd0);
    check("t1.hold_op", 32'(alu_op), 32'd0);
    check("t1.acc", acc, 32'd12);
    take();
    check("t1.cnt", 32'(op_count), 32'(exp_cnt));
    check("t1.valid_low", 32'(res_valid), 32'd0);
    check("t1.ready_back", 32'(cmd_ready), 32'd1);

    // SUB underflow, then accumulate back to zero
    send(5'h02, 32'd0, 32'd1, 1'b0, 1'b0);
    check("t2.sub", res_data, 32'hFFFFFFFF);
    check("t2.sub_err", 32'(res_err), 32'd0);
    take();
    send(5'h01, 32'h12345678, 32'd1, 1'b1, 1'b0);
    check("t2.accadd", res_data, 32'd0);
    check("t2.accadd_zero", 32'(res_zero), 32'd1);
    check("t2.accadd_acc", acc, 32'd0);
    take();

    // Illegal opcode, then a legal one clears the error
    send(5'h1F, 32'd3, 32'd4, 1'b0, 1'b0);
    check("t3.err", 32'(res_err), 32'd1);
    check("t3.data", res_data, 32'd0);
    check("t3.zero", 32'(res_zero), 32'd1);
    take();
    send(5'h03, 32'hF0, 32'h3C, 1'b0, 1'b0);
    check("t3.and", res_data, 32'h30);
    check("t3.err_clr", 32'(res_err), 32'd0);
    take();

    // res_ready in IDLE is ignored
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t4.idle_ready_cnt", 32'(op_count), 32'(exp_cnt));
    check("t4.idle_ready_valid", 32'(res_valid), 32'd0);

    // Backpressure with a queued command waiting
    send(5'h04, 32'd1, 32'd2, 1'b0, 1'b0);
    cmd_valid = 1'b1; cmd_op = 5'h05; cmd_a = 32'hFF; cmd_b = 32'h0F; cmd_acc = 1'b0; cmd_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4.stall_valid", 32'(res_valid), 32'd1);
      check("t4.stall_data", res_data, 32'd3);
      check("t4.stall_ready", 32'(cmd_ready), 32'd0);
      check("t4.stall_op", 32'(alu_op), 32'd0);
    end
    take();
    check("t4.cnt", 32'(op_count), 32'(exp_cnt));
    check("t4.idle_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("t4.queued_op", 32'(alu_op), 32'd5);
    check("t4.queued_a", alu_a, 32'hFF);
    tick();
    check("t4.queued_data", res_data, 32'hF0);
    take();

    // Accumulator clear then XOR, and NOR of zeros
    send(5'h05, 32'h55555555, 32'hA5, 1'b1, 1'b1);
    check("t5.xor", res_data, 32'hA5);
    check("t5.xor_acc", acc, 32'hA5);
    take();
    send(5'h06, 32'd0, 32'd0, 1'b0, 1'b0);
    check("t5.nor", res_data, 32'hFFFFFFFF);
    take();
    check("t5.cnt", 32'(op_count), 32'(exp_cnt));

    // Asynchronous reset while holding a result
    send(5'h01, 32'd2, 32'd3, 1'b0, 1'b0);
    check("t6.pre_valid", 32'(res_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    check_reset_values("t6.rst");
    #1 rst = 1'b0;
    exp_cnt = '0;
    tick();

    // Counter wrap after 2^CNT_W handoffs
    for (int i = 0; i < (1 << CNT_W); i++) begin
      send(5'h01, 32'(i), 32'd1, 1'b0, 1'b0);
      check("t6.wrap_data", res_data, 32'(i + 1));
      take();
      check("t6.wrap_cnt", 32'(op_count), 32'(exp_cnt));
    end
    check("t6.wrap_zero", 32'(op_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
